// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and the register-file write-port priority helper.
// Holds word/register-index typedefs for the default 32x32 configuration.
package cpu_types_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = $clog2(NREGS);
  localparam int MAXW  = 4;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [RAW-1:0]  regbits_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } wport_hit_t;

  // Highest-numbered matching write port wins.
  function automatic wport_hit_t last_hit(
    input logic [MAXW-1:0] m
  );
    wport_hit_t r;
    r = '0;
    for (int j = 0; j < MAXW; j++) begin
      if (m[j]) begin
        r.hit = 1'b1;
        r.idx = j[1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: issue sets busy, writeback clears it.
// Ports: CLK, nRST, iss_en/iss_sel, wen/wsel -> busy_vec.
module regfile_scoreboard #(
  parameter int NREG     = 32,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_sel,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] wsel,
  output logic [NREG-1:0]      busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) busy_d[wsel[j*AW +: AW]] = 1'b0;
    end
    // A new producer outranks a retiring one.
    if (iss_en) busy_d[iss_sel] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass and busy scoreboard.
// Ports: rsel->rdat/rbusy reads, wen/wsel/wdat writes, iss_en/iss_sel, busy_vec.
module regfile_mp
  import cpu_types_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREAD*AW-1:0]  rsel,
  output logic [NREAD*DW-1:0]  rdat,
  output logic [NREAD-1:0]     rbusy,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] wsel,
  input  logic [NWRITE*DW-1:0] wdat,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_sel,
  output logic [NREG-1:0]      busy_vec
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  regfile_scoreboard #(
    .NREG    (NREG),
    .NWRITE  (NWRITE),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_sb (
    .CLK     (CLK),
    .nRST    (nRST),
    .iss_en  (iss_en),
    .iss_sel (iss_sel),
    .wen     (wen),
    .wsel    (wsel),
    .busy_vec(busy_vec)
  );

  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) regs_d[wsel[j*AW +: AW]] = wdat[j*DW +: DW];
    end
    if (ZERO_REG != 0) regs_d[0] = '0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   rs;
    logic [MAXW-1:0] m;
    wport_hit_t      h;
    logic [DW-1:0]   rd;
    logic            rb;

    assign rs = rsel[i*AW +: AW];

    always_comb begin
      m = '0;
      for (int j = 0; j < NWRITE; j++) begin
        m[j] = wen[j] && (wsel[j*AW +: AW] == rs);
      end
    end

    assign h = last_hit(m);

    always_comb begin
      rd = regs_q[rs];
      rb = busy_vec[rs];
      if (BYPASS != 0 && h.hit) begin
        rd = wdat[int'(h.idx)*DW +: DW];
        rb = 1'b0;
      end
      if (ZERO_REG != 0 && rs == '0) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdat[i*DW +: DW] = rd;
    assign rbusy[i]         = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array model.
// Two instances (bypass on/off) share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        nrst;
  logic [9:0]  rsel;
  logic [63:0] rdat, rdat_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic [1:0]  wen;
  logic [9:0]  wsel;
  logic [63:0] wdat;
  logic        iss_en;
  logic [4:0]  iss_sel;
  logic [31:0] busy_vec, busy_vec_nb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  bit          bsy [32];

  always #5 clk = ~clk;

  regfile_mp #(
    .DW(32), .NREG(32), .NREAD(2), .NWRITE(2),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .CLK(clk), .nRST(nrst), .rsel(rsel), .rdat(rdat),
    .rbusy(rbusy), .wen(wen), .wsel(wsel), .wdat(wdat),
    .iss_en(iss_en), .iss_sel(iss_sel), .busy_vec(busy_vec)
  );

  regfile_mp #(
    .DW(32), .NREG(32), .NREAD(2), .NWRITE(2),
    .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .CLK(clk), .nRST(nrst), .rsel(rsel), .rdat(rdat_nb),
    .rbusy(rbusy_nb), .wen(wen), .wsel(wsel), .wdat(wdat),
    .iss_en(iss_en), .iss_sel(iss_sel), .busy_vec(busy_vec_nb)
  );

  function automatic logic [31:0] m_rd(input logic [4:0] s, input bit byp);
    logic [31:0] v;
    v = mem[s];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (wen[j] && wsel[j*5 +: 5] == s) v = wdat[j*32 +: 32];
    if (s == 0) v = 0;
    return v;
  endfunction

  function automatic logic m_rb(input logic [4:0] s, input bit byp);
    bit hit;
    hit = 0;
    for (int j = 0; j < 2; j++)
      if (wen[j] && wsel[j*5 +: 5] == s) hit = 1;
    return (s != 0) && bsy[s] && !(byp && hit);
  endfunction

  function automatic logic [31:0] m_bv();
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = bsy[k];
    return v;
  endfunction

  task automatic model_step();
    if (!nrst) begin
      for (int k = 0; k < 32; k++) begin
        mem[k] = 0;
        bsy[k] = 0;
      end
    end else begin
      for (int j = 0; j < 2; j++)
        if (wen[j]) begin
          if (wsel[j*5 +: 5] != 0) mem[wsel[j*5 +: 5]] = wdat[j*32 +: 32];
          bsy[wsel[j*5 +: 5]] = 0;
        end
      if (iss_en && iss_sel != 0) bsy[iss_sel] = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 0; wsel = 0; wdat = 0; iss_en = 0; iss_sel = 0;
  endtask

  task automatic test_reset();
    nrst = 0; rsel = 0; idle();
    tick(); tick();
    rsel[4:0] = 5; #1;
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy: got %h want 0", busy_vec);
    end
    checks++;
    if (rdat[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdat: got %h want 0", rdat[31:0]);
    end
    nrst = 1; wen = 2'b01; wsel[4:0] = 5; wdat[31:0] = 32'hDEAD;
    tick();
    idle(); #1;
    checks++;
    if (rdat_nb[31:0] !== 32'hDEAD) begin
      errors++;
      $display("FAIL reset_pre_write: got %h want dead", rdat_nb[31:0]);
    end
    nrst = 0; wen = 2'b01; wsel[4:0] = 5; wdat[31:0] = 32'hBEEF;
    iss_en = 1; iss_sel = 5;
    tick();
    nrst = 1; idle(); #1;
    checks++;
    if (rdat[31:0] !== 32'h0 || rdat_nb[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_lost: got %h/%h want 0",
               rdat[31:0], rdat_nb[31:0]);
    end
    checks++;
    if (busy_vec !== 32'h0 || busy_vec_nb !== 32'h0) begin
      errors++;
      $display("FAIL reset_iss_lost: got %h want 0", busy_vec);
    end
  endtask

  task automatic test_zero_reg();
    wen = 2'b01; wsel[4:0] = 0; wdat[31:0] = 32'hFFFFFFFF;
    iss_en = 1; iss_sel = 0; rsel = 0;
    tick();
    idle(); #1;
    checks++;
    if (rdat[31:0] !== 0 || rdat_nb[31:0] !== 0) begin
      errors++;
      $display("FAIL zero_rdat: got %h/%h want 0",
               rdat[31:0], rdat_nb[31:0]);
    end
    checks++;
    if (rbusy[0] !== 1'b0 || busy_vec[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy: got %b/%b want 0/0", rbusy[0], busy_vec[0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    old = mem[7];
    rsel[4:0] = 7;
    wen = 2'b01; wsel[4:0] = 7; wdat[31:0] = 32'h1234;
    #1;
    checks++;
    if (rdat[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h want 1234", rdat[31:0]);
    end
    checks++;
    if (rdat_nb[31:0] !== old) begin
      errors++;
      $display("FAIL nobypass_old: got %h want %h", rdat_nb[31:0], old);
    end
    tick();
    idle(); #1;
    checks++;
    if (rdat_nb[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL nobypass_next: got %h want 1234", rdat_nb[31:0]);
    end
  endtask

  task automatic test_write_prio();
    rsel = {5'd0, 5'd3};
    wen = 2'b11; wsel = {5'd3, 5'd3};
    wdat = {32'hBB, 32'hAA};
    #1;
    checks++;
    if (rdat[31:0] !== 32'hBB) begin
      errors++;
      $display("FAIL prio_bypass: got %h want bb", rdat[31:0]);
    end
    tick();
    idle(); #1;
    checks++;
    if (rdat[31:0] !== 32'hBB || rdat_nb[31:0] !== 32'hBB) begin
      errors++;
      $display("FAIL prio_stored: got %h/%h want bb",
               rdat[31:0], rdat_nb[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_sel = 9; rsel[4:0] = 9;
    tick();
    idle(); #1;
    checks++;
    if (rbusy[0] !== 1'b1 || rbusy_nb[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue: got %b/%b want 1/1", rbusy[0], rbusy_nb[0]);
    end
    wen = 2'b10; wsel[9:5] = 9; wdat[63:32] = 32'h99;
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || rbusy_nb[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_cycle: got %b/%b want 0/1", rbusy[0], rbusy_nb[0]);
    end
    tick();
    idle(); #1;
    checks++;
    if (rbusy[0] !== 1'b0 || rbusy_nb[0] !== 1'b0 || busy_vec[9] !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: got %b/%b/%b want 0/0/0",
               rbusy[0], rbusy_nb[0], busy_vec[9]);
    end
  endtask

  task automatic test_issue_and_write();
    iss_en = 1; iss_sel = 4;
    wen = 2'b01; wsel[4:0] = 4; wdat[31:0] = 32'h4444;
    rsel[4:0] = 4;
    tick();
    idle(); #1;
    checks++;
    if (busy_vec[4] !== 1'b1 || busy_vec_nb[4] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b want 1", busy_vec[4]);
    end
    checks++;
    if (rdat[31:0] !== 32'h4444) begin
      errors++;
      $display("FAIL set_wins_data: got %h want 4444", rdat[31:0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      nrst    = ($urandom_range(0, 59) != 0);
      wen     = 2'($urandom);
      wsel    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdat    = {$urandom, $urandom};
      iss_en  = ($urandom_range(0, 2) == 0);
      iss_sel = 5'($urandom_range(0, 7));
      rsel    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rdat[i*32 +: 32] !== m_rd(rsel[i*5 +: 5], 1)) begin
          errors++;
          $display("FAIL rnd_rdat%0d: got %h want %h", i,
                   rdat[i*32 +: 32], m_rd(rsel[i*5 +: 5], 1));
        end
        checks++;
        if (rdat_nb[i*32 +: 32] !== m_rd(rsel[i*5 +: 5], 0)) begin
          errors++;
          $display("FAIL rnd_rdat_nb%0d: got %h want %h", i,
                   rdat_nb[i*32 +: 32], m_rd(rsel[i*5 +: 5], 0));
        end
        checks++;
        if (rbusy[i] !== m_rb(rsel[i*5 +: 5], 1) ||
            rbusy_nb[i] !== m_rb(rsel[i*5 +: 5], 0)) begin
          errors++;
          $display("FAIL rnd_rbusy%0d: got %b/%b want %b/%b", i,
                   rbusy[i], rbusy_nb[i],
                   m_rb(rsel[i*5 +: 5], 1), m_rb(rsel[i*5 +: 5], 0));
        end
      end
      checks++;
      if (busy_vec !== m_bv() || busy_vec_nb !== m_bv()) begin
        errors++;
        $display("FAIL rnd_busy_vec: got %h/%h want %h",
                 busy_vec, busy_vec_nb, m_bv());
      end
      tick();
    end
    nrst = 1;
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_write_prio();
    test_scoreboard();
    test_issue_and_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
